// File: rtl/alu_core.sv
// alu_core: registered ALU that gathers split operands and presents the result and flags one edge later
module alu_core #(
  parameter int N = 8,
  parameter int M = 4,
  parameter int WAIT_CYCLES = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         CE,
  input  logic [1:0]   INP_VALID,
  input  logic         MODE,
  input  logic [M-1:0] CMD,
  input  logic         CIN,
  input  logic [N-1:0] OPA,
  input  logic [N-1:0] OPB,
  output logic [N:0]   RES,
  output logic         COUT,
  output logic         OFLOW,
  output logic         E,
  output logic         G,
  output logic         L,
  output logic         ERR
);
  localparam int SW = $clog2(N);
  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] C_MAX = CW'(WAIT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, WAIT_A, WAIT_B} state_t;
  state_t r_state, w_nstate;
  logic [CW-1:0] r_cnt, w_ncnt;
  logic [N-1:0] r_a, r_b, w_a, w_b, w_lg, w_rol, w_ror;
  logic [M-1:0] r_cmd, w_cmd;
  logic r_mode, r_cin, w_mode, w_cin, w_idle;
  logic [N:0] r_res, w_res, w_ax, w_bx, w_cx;
  logic r_cout, r_oflow, r_e, r_g, r_l, r_err;
  logic w_cout, w_oflow, w_e, w_g, w_l, w_err;
  logic w_a_only, w_b_only, w_bad, w_upd, w_zerr, w_lat_a, w_lat_b;
  logic [SW-1:0] w_sh;
  // While waiting, the held operand and command come from the latches, the missing operand from the port
  assign w_idle   = r_state == IDLE;
  assign w_a      = r_state == WAIT_B ? r_a : OPA;
  assign w_b      = r_state == WAIT_A ? r_b : OPB;
  assign w_cmd    = w_idle ? CMD : r_cmd;
  assign w_mode   = w_idle ? MODE : r_mode;
  assign w_cin    = w_idle ? CIN : r_cin;
  assign w_a_only = MODE ? (int'(CMD) == 4 || int'(CMD) == 5)
                         : (int'(CMD) == 6 || int'(CMD) == 8 || int'(CMD) == 9);
  assign w_b_only = MODE ? (int'(CMD) == 6 || int'(CMD) == 7)
                         : (int'(CMD) == 7 || int'(CMD) == 10 || int'(CMD) == 11);
  assign w_bad    = MODE ? int'(CMD) > 8 : int'(CMD) > 13;
  assign w_ax     = {1'b0, w_a};
  assign w_bx     = {1'b0, w_b};
  assign w_cx     = {{N{1'b0}}, w_cin};
  assign w_sh     = w_b[SW-1:0];
  assign w_ror    = N'({w_a, w_a} >> w_sh);
  assign w_rol    = N'({w_a, w_a} >> (N - int'(w_sh)));
  always_comb begin
    w_res = '0;
    w_lg = '0;
    w_cout = 1'b0;
    w_oflow = 1'b0;
    w_e = 1'b0;
    w_g = 1'b0;
    w_l = 1'b0;
    w_err = 1'b0;
    if (w_mode) begin
      case (int'(w_cmd))
        0: begin w_res = w_ax + w_bx; w_cout = w_res[N]; end
        1: begin w_res = w_ax - w_bx; w_oflow = w_a < w_b; end
        2: begin w_res = w_ax + w_bx + w_cx; w_cout = w_res[N]; end
        3: begin w_res = w_ax - w_bx - w_cx; w_oflow = w_ax < w_bx + w_cx; end
        4: begin w_res = w_ax + 1'b1; w_cout = w_res[N]; end
        5: begin w_res = w_ax - 1'b1; w_oflow = w_a == '0; end
        6: begin w_res = w_bx + 1'b1; w_cout = w_res[N]; end
        7: begin w_res = w_bx - 1'b1; w_oflow = w_b == '0; end
        8: begin w_e = w_a == w_b; w_g = w_a > w_b; w_l = w_a < w_b; end
        default: w_err = 1'b1;
      endcase
    end else begin
      case (int'(w_cmd))
        0: w_lg = w_a & w_b;
        1: w_lg = ~(w_a & w_b);
        2: w_lg = w_a | w_b;
        3: w_lg = ~(w_a | w_b);
        4: w_lg = w_a ^ w_b;
        5: w_lg = ~(w_a ^ w_b);
        6: w_lg = ~w_a;
        7: w_lg = ~w_b;
        8: w_lg = w_a >> 1;
        9: w_lg = w_a << 1;
        10: w_lg = w_b >> 1;
        11: w_lg = w_b << 1;
        12: begin w_lg = w_rol; w_err = |w_b[N-1:SW]; end
        13: begin w_lg = w_ror; w_err = |w_b[N-1:SW]; end
        default: w_err = 1'b1;
      endcase
      w_res = {1'b0, w_lg};
    end
  end
  always_comb begin
    w_nstate = r_state;
    w_ncnt = r_cnt;
    w_upd = 1'b0;
    w_zerr = 1'b0;
    w_lat_a = 1'b0;
    w_lat_b = 1'b0;
    case (r_state)
      IDLE: begin
        if (INP_VALID == 2'b11 || (w_bad && |INP_VALID)) w_upd = 1'b1;
        else if ((w_a_only && INP_VALID == 2'b01) || (w_b_only && INP_VALID == 2'b10)) w_upd = 1'b1;
        else if (w_a_only || w_b_only) w_zerr = |INP_VALID;
        else if (INP_VALID == 2'b01) begin w_lat_a = 1'b1; w_nstate = WAIT_B; w_ncnt = '0; end
        else if (INP_VALID == 2'b10) begin w_lat_b = 1'b1; w_nstate = WAIT_A; w_ncnt = '0; end
      end
      WAIT_A, WAIT_B: begin
        if (r_state == WAIT_A ? INP_VALID[0] : INP_VALID[1]) begin w_upd = 1'b1; w_nstate = IDLE; end
        else if (r_cnt == C_MAX) begin w_zerr = 1'b1; w_nstate = IDLE; w_ncnt = '0; end
        else w_ncnt = r_cnt + CW'(1);
      end
      default: w_nstate = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_a <= '0;
      r_b <= '0;
      r_cmd <= '0;
      r_mode <= 1'b0;
      r_cin <= 1'b0;
      r_res <= '0;
      r_cout <= 1'b0;
      r_oflow <= 1'b0;
      r_e <= 1'b0;
      r_g <= 1'b0;
      r_l <= 1'b0;
      r_err <= 1'b0;
    end else if (CE) begin
      r_state <= w_nstate;
      r_cnt <= w_ncnt;
      if (w_lat_a) r_a <= OPA;
      if (w_lat_b) r_b <= OPB;
      if (w_lat_a || w_lat_b) begin
        r_cmd <= CMD;
        r_mode <= MODE;
        r_cin <= CIN;
      end
      if (w_upd || w_zerr) begin
        r_res <= w_zerr ? '0 : w_res;
        r_cout <= !w_zerr && w_cout;
        r_oflow <= !w_zerr && w_oflow;
        r_e <= !w_zerr && w_e;
        r_g <= !w_zerr && w_g;
        r_l <= !w_zerr && w_l;
        r_err <= w_zerr || w_err;
      end
    end
  end
  assign RES = r_res;
  assign COUT = r_cout;
  assign OFLOW = r_oflow;
  assign E = r_e;
  assign G = r_g;
  assign L = r_l;
  assign ERR = r_err;
endmodule
